// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the decode/execute boundary and the ALU it feeds.
package id_ex_operand_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_AW     = 5;
    localparam int IMM_W      = 16;
    localparam int ALU_CTRL_W = 2;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_e;

    // A bubble carries AND so the ALU sees a harmless, side-effect-free op.
    localparam alu_op_e ALU_OP_BUBBLE = ALU_AND;

endpackage

// File: rtl/id_ex_operand_stage_reg_file.sv
// 2-read / 1-write architectural register file with write-first bypass.
// Register 0 is hard-wired to zero; all entries clear on async reset.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [REG_AW-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [REG_AW-1:0] i_rd1_addr,
    input  logic [REG_AW-1:0] i_rd2_addr,
    output logic [DATA_W-1:0] o_rd1_data,
    output logic [DATA_W-1:0] o_rd2_data
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] r_mem [NREG];
    logic              w_wr_live;

    assign w_wr_live = i_wr_en && (i_wr_addr != '0);

    // A same-cycle write to the addressed register wins over stored contents.
    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (w_wr_live && (i_wr_addr == addr)) begin
            return i_wr_data;
        end else begin
            return r_mem[addr];
        end
    endfunction

    // Storage update; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd1_data = read_port(i_rd1_addr);
    assign o_rd2_data = read_port(i_rd2_addr);

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: register read with bypass, immediate extension,
// operand-2 select and the registered boundary that feeds the ALU.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W,
    parameter int REG_AW = id_ex_operand_stage_pkg::REG_AW,
    parameter int IMM_W  = id_ex_operand_stage_pkg::IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [REG_AW-1:0] RsAddr,
    input  logic [REG_AW-1:0] RtAddr,
    input  logic [IMM_W-1:0]  Imm,
    input  logic              ALUSrc,
    input  logic              SignExt,
    input  logic [1:0]        ALUControlIn,
    input  logic [REG_AW-1:0] RdAddrIn,
    input  logic              RegWriteIn,
    input  logic              WbEn,
    input  logic [REG_AW-1:0] WbAddr,
    input  logic [DATA_W-1:0] WbData,
    output logic [DATA_W-1:0] Operand1,
    output logic [DATA_W-1:0] Operand2,
    output logic [1:0]        ALUControl,
    output logic [DATA_W-1:0] StoreData,
    output logic [REG_AW-1:0] ExRdAddr,
    output logic              ExRegWrite,
    output logic              ExValid
);

    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_op2_next;

    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_store;
    alu_op_e           r_alu_ctrl;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_reg_write;
    logic              r_valid;

    reg_file_2r1w #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (WbEn),
        .i_wr_addr  (WbAddr),
        .i_wr_data  (WbData),
        .i_rd1_addr (RsAddr),
        .i_rd2_addr (RtAddr),
        .o_rd1_data (w_rs_val),
        .o_rd2_data (w_rt_val)
    );

    assign w_imm_ext  = SignExt ? {{(DATA_W-IMM_W){Imm[IMM_W-1]}}, Imm}
                                : {{(DATA_W-IMM_W){1'b0}}, Imm};
    assign w_op2_next = ALUSrc ? w_imm_ext : w_rt_val;

    // Pipeline boundary: flush beats stall, stall holds, invalid slot bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1       <= '0;
            r_op2       <= '0;
            r_store     <= '0;
            r_alu_ctrl  <= ALU_OP_BUBBLE;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
        end else if (Flush || (!Stall && !InValid)) begin
            r_op1       <= '0;
            r_op2       <= '0;
            r_store     <= '0;
            r_alu_ctrl  <= ALU_OP_BUBBLE;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
        end else if (!Stall) begin
            r_op1       <= w_rs_val;
            r_op2       <= w_op2_next;
            r_store     <= w_rt_val;
            r_alu_ctrl  <= alu_op_e'(ALUControlIn);
            r_rd_addr   <= RdAddrIn;
            r_reg_write <= RegWriteIn;
            r_valid     <= 1'b1;
        end
    end

    assign Operand1   = r_op1;
    assign Operand2   = r_op2;
    assign StoreData  = r_store;
    assign ALUControl = r_alu_ctrl;
    assign ExRdAddr   = r_rd_addr;
    assign ExRegWrite = r_reg_write;
    assign ExValid    = r_valid;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
Decode-to-execute stage that sits directly upstream of the ALU and produces its Operand1, Operand2 and ALUControl inputs.
- Contains the 32x32 architectural register file with two read ports and one write port.
- Write-to-read bypass from writeback; immediate sign/zero extension; operand-2 source select.
- Registered ID/EX pipeline boundary with stall and flush.
- All ALU-bound outputs are registered, so the ALU sees stable operands for a full cycle.

Parameters:
DATA_W, 32, datapath width; Operand1/Operand2/WbData width.
REG_AW, 5, register address width; register count = 2**REG_AW.
IMM_W, 16, immediate field width before extension.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
Stall  in  1  hold the ID/EX register contents.
Flush  in  1  load a bubble into the ID/EX register.
InValid  in  1  decode slot holds a real instruction.
RsAddr  in  REG_AW  source register 1 address.
RtAddr  in  REG_AW  source register 2 address.
Imm  in  IMM_W  raw immediate field.
ALUSrc  in  1  1: Operand2 = extended immediate; 0: Operand2 = Rt value.
SignExt  in  1  1: sign-extend Imm; 0: zero-extend Imm.
ALUControlIn  in  2  decoded ALU op (AND 00, OR 01, ADD 10, SUB 11).
RdAddrIn  in  REG_AW  destination register address.
RegWriteIn  in  1  instruction writes a register.
WbEn  in  1  writeback write enable.
WbAddr  in  REG_AW  writeback address.
WbData  in  DATA_W  writeback data.
Operand1  out  DATA_W  to ALU Operand1.
Operand2  out  DATA_W  to ALU Operand2.
ALUControl  out  2  to ALU ALUControl.
StoreData  out  DATA_W  Rt value after bypass, for the memory stage.
ExRdAddr  out  REG_AW  destination address carried to EX.
ExRegWrite  out  1  register write enable carried to EX; gated by valid.
ExValid  out  1  EX slot holds a real instruction.

Behaviour:
Reset (rst_n low, asynchronous):
- All ID/EX outputs go to 0 immediately: Operand1, Operand2, StoreData, ALUControl=00, ExRdAddr, ExRegWrite, ExValid.
- All register-file entries clear to 0.
- Reset asserted mid-operation discards in-flight state the same way.
- The first capture occurs on the first rising clk edge after rst_n deasserts.

Register file:
- Write on rising clk when WbEn=1 and WbAddr!=0.
- Register 0 always reads 0; writes to register 0 are ignored.
- Reads are combinational.
- Bypass: if WbEn=1, WbAddr!=0 and WbAddr equals the read address, the read returns WbData in the same cycle (write-first).
- Writeback proceeds regardless of Stall and Flush.

Immediate and operand select:
- Extended immediate: SignExt=1 -> replicate Imm[IMM_W-1] into the upper bits; SignExt=0 -> upper bits 0.
- Operand2 next value = ALUSrc ? extended immediate : bypassed Rt.
- Operand1 next value = bypassed Rs.
- StoreData next value = bypassed Rt, regardless of ALUSrc.

ID/EX register update, evaluated at each rising clk in priority order:
1. Flush=1 -> bubble: ExValid=0, ExRegWrite=0, ALUControl=00, Operand1=Operand2=StoreData=0, ExRdAddr=0. Flush overrides Stall.
2. Stall=1 -> all outputs hold their values.
3. InValid=0 -> bubble, same values as Flush.
4. Otherwise capture: ExValid=1; ExRegWrite=RegWriteIn; ExRdAddr=RdAddrIn; ALUControl=ALUControlIn; operands as above.

Timing:
- Latency is one cycle from decode inputs to ALU inputs.
- Throughput is one instruction per cycle when not stalled.
- During a stall, a writeback that targets a held instruction's source is not re-captured into the held operands. The upstream hazard unit re-issues if required.

Decomposition:
- Shared package, common with the ALU: ALU op encodings (AND 00, OR 01, ADD 10, SUB 11), the bubble op constant (AND), DATA_W, and REG_AW.
- One sub-module: reg_file_2r1w, holding the storage, the register-0 rule, the write-first bypass and the asynchronous clear.
- Extension, operand muxing and the ID/EX register stay in the top module.

Test Plan:
- Reset: hold rst_n=0, drive arbitrary inputs -> all outputs 0; read of any register after release returns 0.
- Write then read: WbEn=1, WbAddr=5, WbData=0x1234_5678, same cycle RsAddr=5 -> next edge Operand1=0x1234_5678 (bypass).
- Register 0: WbEn=1, WbAddr=0, WbData=0xFFFF_FFFF; RsAddr=0 -> Operand1=0, in that cycle and all later cycles.
- Immediate select: Imm=0x8001, ALUSrc=1, SignExt=1 -> Operand2=0xFFFF_8001; SignExt=0 -> 0x0000_8001.
- Stall/flush: capture an ADD with R1=7, R2=3, then Stall=1 for 3 cycles with changing inputs -> outputs hold 7/3/10. Then Stall=1 together with Flush=1 -> ExValid=0, ExRegWrite=0, ALUControl=00.
- Reset mid-stream: pulse rst_n low between clk edges while ExValid=1 -> outputs clear without a clock edge; register file reads 0 afterward.
